// File: rtl/delay_correlator.sv
// delay_correlator: per-phase x[n]*conj(x[n-D]) correlation, summed across phases
// and over a sliding window of WIN valid clocks, with a thresholded
// packet-detect FSM (confirmation run followed by blanking).
module delay_correlator #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned PHASES    = 16,
  parameter int unsigned WIN       = 32,
  parameter int unsigned CONFIRM   = 4,
  parameter int unsigned BLANK     = 64,
  localparam int unsigned SW = 2 * DATAWIDTH + 1 + $clog2(PHASES),
  localparam int unsigned AW = SW + $clog2(WIN),
  localparam int unsigned MW = AW + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  input  logic [PHASES*DATAWIDTH-1:0]   cur_re_i,
  input  logic [PHASES*DATAWIDTH-1:0]   cur_im_i,
  input  logic [PHASES*DATAWIDTH-1:0]   dly_re_i,
  input  logic [PHASES*DATAWIDTH-1:0]   dly_im_i,
  input  logic [MW-1:0]                 threshold_i,
  output logic signed [AW-1:0]          corr_re_o,
  output logic signed [AW-1:0]          corr_im_o,
  output logic                          corr_valid_o,
  output logic                          detect_o,
  output logic [1:0]                    state_o
);

  localparam int unsigned PW   = 2 * DATAWIDTH + 1;
  localparam int unsigned LW   = PHASES * DATAWIDTH;
  localparam int unsigned CMAX = (WIN > BLANK) ? ((WIN > CONFIRM) ? WIN : CONFIRM)
                                               : ((BLANK > CONFIRM) ? BLANK : CONFIRM);
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned FW   = $clog2(WIN + 1);

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_SEARCH  = 2'd1,
    S_CONFIRM = 2'd2,
    S_BLANK   = 2'd3
  } state_t;

  // Extract one phase lane, sign-extended to product width.
  function automatic logic signed [PW-1:0] lane(input logic [LW-1:0] vec,
                                                input int unsigned p);
    return PW'($signed(vec[p*DATAWIDTH +: DATAWIDTH]));
  endfunction

  logic signed [PW-1:0] prod_re_d [PHASES];
  logic signed [PW-1:0] prod_im_d [PHASES];
  logic signed [PW-1:0] prod_re_q [PHASES];
  logic signed [PW-1:0] prod_im_q [PHASES];
  logic                 v1_q;

  logic signed [SW-1:0] sum_re_d, sum_im_d;
  logic signed [SW-1:0] sum_re_q, sum_im_q;
  logic                 v2_q;

  logic signed [SW-1:0] hist_re_q [WIN];
  logic signed [SW-1:0] hist_im_q [WIN];
  logic signed [AW-1:0] acc_re_q, acc_im_q;
  logic signed [AW-1:0] acc_re_d, acc_im_d;
  logic                 acc_v_q;
  logic [FW-1:0]        fill_q;
  logic                 filled;

  logic signed [MW-1:0] ext_re, ext_im;
  logic [MW-1:0]        mag_re, mag_im, metric;
  logic                 above;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;

  // Per-phase conjugate products (full precision).
  always_comb begin
    for (int unsigned p = 0; p < PHASES; p++) begin
      prod_re_d[p] = lane(cur_re_i, p) * lane(dly_re_i, p)
                   + lane(cur_im_i, p) * lane(dly_im_i, p);
      prod_im_d[p] = lane(cur_im_i, p) * lane(dly_re_i, p)
                   - lane(cur_re_i, p) * lane(dly_im_i, p);
    end
  end

  // Stage 1: register products on valid input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      for (int unsigned p = 0; p < PHASES; p++) begin
        prod_re_q[p] <= '0;
        prod_im_q[p] <= '0;
      end
    end else begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        prod_re_q <= prod_re_d;
        prod_im_q <= prod_im_d;
      end
    end
  end

  // Block sum across phases.
  always_comb begin
    sum_re_d = '0;
    sum_im_d = '0;
    for (int unsigned p = 0; p < PHASES; p++) begin
      sum_re_d = sum_re_d + SW'(prod_re_q[p]);
      sum_im_d = sum_im_d + SW'(prod_im_q[p]);
    end
  end

  // Stage 2: register the block sum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2_q     <= 1'b0;
      sum_re_q <= '0;
      sum_im_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_re_q <= sum_re_d;
        sum_im_q <= sum_im_d;
      end
    end
  end

  // Sliding window update: add newest block, drop the one leaving the window.
  assign acc_re_d = acc_re_q + AW'(sum_re_q) - AW'(hist_re_q[WIN-1]);
  assign acc_im_d = acc_im_q + AW'(sum_im_q) - AW'(hist_im_q[WIN-1]);
  assign filled   = (fill_q == FW'(WIN));

  // Stage 3: accumulator, history shift and visible outputs (hidden until filled).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      acc_v_q      <= 1'b0;
      fill_q       <= '0;
      corr_re_o    <= '0;
      corr_im_o    <= '0;
      corr_valid_o <= 1'b0;
      for (int unsigned i = 0; i < WIN; i++) begin
        hist_re_q[i] <= '0;
        hist_im_q[i] <= '0;
      end
    end else begin
      acc_v_q      <= v2_q;
      corr_valid_o <= v2_q && filled;
      if (v2_q) begin
        acc_re_q     <= acc_re_d;
        acc_im_q     <= acc_im_d;
        hist_re_q[0] <= sum_re_q;
        hist_im_q[0] <= sum_im_q;
        for (int unsigned i = 1; i < WIN; i++) begin
          hist_re_q[i] <= hist_re_q[i-1];
          hist_im_q[i] <= hist_im_q[i-1];
        end
        if (!filled) begin
          fill_q <= fill_q + FW'(1);
        end else begin
          corr_re_o <= acc_re_d;
          corr_im_o <= acc_im_d;
        end
      end
    end
  end

  // L1 magnitude of the current window and threshold compare.
  always_comb begin
    ext_re = MW'(acc_re_q);
    ext_im = MW'(acc_im_q);
    mag_re = ext_re[MW-1] ? $unsigned(-ext_re) : $unsigned(ext_re);
    mag_im = ext_im[MW-1] ? $unsigned(-ext_im) : $unsigned(ext_im);
    metric = mag_re + mag_im;
    above  = (metric >= threshold_i);
  end

  // Detect FSM, stepped once per window output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_FILL;
      cnt_q    <= '0;
      detect_o <= 1'b0;
    end else begin
      detect_o <= 1'b0;
      if (acc_v_q) begin
        case (state_q)
          S_FILL: begin
            if (cnt_q == CW'(WIN - 1)) begin
              state_q <= S_SEARCH;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_SEARCH: begin
            if (above) begin
              if (CONFIRM == 1) begin
                detect_o <= 1'b1;
                state_q  <= S_BLANK;
                cnt_q    <= '0;
              end else begin
                state_q <= S_CONFIRM;
                cnt_q   <= CW'(1);
              end
            end
          end
          S_CONFIRM: begin
            if (!above) begin
              state_q <= S_SEARCH;
              cnt_q   <= '0;
            end else if (cnt_q == CW'(CONFIRM - 1)) begin
              detect_o <= 1'b1;
              state_q  <= S_BLANK;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_BLANK: begin
            if (cnt_q == CW'(BLANK - 1)) begin
              state_q <= S_SEARCH;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign state_o = state_q;

endmodule
